// File: rtl/dram_addr_sequencer_if.sv
// Request/response bundle between the bus side and the DRAM address sequencer.
// The master modport is the sequencer view; the slave modport is the requester view.
interface dram_addr_sequencer_if #(
  parameter int ROW_ADDR_DEPTH = 8,
  parameter int COL_ADDR_DEPTH = 8
);
  logic                                     ReqValid;
  logic                                     ReqReady;
  logic                                     ReqWrite;
  logic [ROW_ADDR_DEPTH+COL_ADDR_DEPTH-1:0] ReqAddr;
  logic [ROW_ADDR_DEPTH-1:0]                AddrOut;
  logic                                     RAS;
  logic                                     CAS;
  logic                                     WE;
  logic                                     Done;
  logic                                     Busy;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr,
    output ReqReady, AddrOut, RAS, CAS, WE, Done, Busy
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr,
    input  ReqReady, AddrOut, RAS, CAS, WE, Done, Busy
  );
endinterface

// File: rtl/dram_addr_sequencer.sv
// Multiplexed DRAM address initiator: row under RAS, column under CAS, with
// tRCD/tCL/tRP spacing enforced by a single down-counter.
module dram_addr_sequencer #(
  parameter int ROW_ADDR_DEPTH = 8,
  parameter int COL_ADDR_DEPTH = 8,
  parameter int T_RCD          = 2,
  parameter int T_CL           = 2,
  parameter int T_RP           = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dram_addr_sequencer_if.master bus
);
  localparam int MAX_T = (T_RCD > T_CL) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                        : ((T_CL > T_RP) ? T_CL : T_RP);
  localparam int CW = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_RCD_WAIT, S_COL, S_CL_WAIT, S_DONE, S_PRE
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [ROW_ADDR_DEPTH-1:0] row_q, row_d;
  logic [COL_ADDR_DEPTH-1:0] col_q, col_d;
  logic                      wr_q, wr_d;
  logic [ROW_ADDR_DEPTH-1:0] addr_q, addr_d;
  logic                      ras_q, ras_d;
  logic                      cas_q, cas_d;
  logic                      we_q, we_d;
  logic                      done_q, done_d;
  logic                      accept;

  assign bus.ReqReady = (state_q == S_IDLE) & ~reset;
  assign accept       = bus.ReqValid & bus.ReqReady;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACT;
          row_d   = bus.ReqAddr[ROW_ADDR_DEPTH+COL_ADDR_DEPTH-1:COL_ADDR_DEPTH];
          col_d   = bus.ReqAddr[COL_ADDR_DEPTH-1:0];
          wr_d    = bus.ReqWrite;
        end
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_RCD_WAIT;
          cnt_d   = CW'(T_RCD - 1);
        end else begin
          state_d = S_COL;
        end
      end
      S_RCD_WAIT: begin
        if (cnt_q == ONE) begin
          state_d = S_COL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_COL: begin
        if (T_CL > 1) begin
          state_d = S_CL_WAIT;
          cnt_d   = CW'(T_CL - 1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_CL_WAIT: begin
        if (cnt_q == ONE) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE: begin
        state_d = S_PRE;
        cnt_d   = CW'(T_RP);
      end
      S_PRE: begin
        if (cnt_q == ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    addr_d = '0;
    ras_d  = 1'b0;
    cas_d  = 1'b0;
    we_d   = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_ACT: begin
        ras_d  = 1'b1;
        addr_d = row_d;
      end
      S_RCD_WAIT: addr_d = row_d;
      S_COL: begin
        cas_d  = 1'b1;
        we_d   = wr_d;
        addr_d = ROW_ADDR_DEPTH'(col_d);
      end
      S_CL_WAIT: addr_d = ROW_ADDR_DEPTH'(col_d);
      S_DONE: begin
        done_d = 1'b1;
        addr_d = ROW_ADDR_DEPTH'(col_d);
      end
      default: addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      ras_q   <= 1'b0;
      cas_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign bus.AddrOut = addr_q;
  assign bus.RAS     = ras_q;
  assign bus.CAS     = cas_q;
  assign bus.WE      = we_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_dram_addr_sequencer.sv
// Directed bench: three sequencer instances (default timing, minimum timing,
// narrow column) checked cycle by cycle against hand-derived timelines.
module tb_dram_addr_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   sel;

  always #5 clk = ~clk;

  dram_addr_sequencer_if #(.ROW_ADDR_DEPTH(8), .COL_ADDR_DEPTH(8)) ifa ();
  dram_addr_sequencer_if #(.ROW_ADDR_DEPTH(8), .COL_ADDR_DEPTH(8)) ifb ();
  dram_addr_sequencer_if #(.ROW_ADDR_DEPTH(8), .COL_ADDR_DEPTH(6)) ifc ();

  dram_addr_sequencer #(.ROW_ADDR_DEPTH(8), .COL_ADDR_DEPTH(8), .T_RCD(2), .T_CL(2), .T_RP(2))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  dram_addr_sequencer #(.ROW_ADDR_DEPTH(8), .COL_ADDR_DEPTH(8), .T_RCD(1), .T_CL(1), .T_RP(1))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  dram_addr_sequencer #(.ROW_ADDR_DEPTH(8), .COL_ADDR_DEPTH(6), .T_RCD(2), .T_CL(2), .T_RP(2))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  logic [7:0] o_addr;
  logic       o_ready, o_ras, o_cas, o_we, o_done, o_busy;

  always_comb begin
    case (sel)
      0: begin
        o_addr = ifa.AddrOut; o_ready = ifa.ReqReady; o_ras = ifa.RAS;
        o_cas = ifa.CAS; o_we = ifa.WE; o_done = ifa.Done; o_busy = ifa.Busy;
      end
      1: begin
        o_addr = ifb.AddrOut; o_ready = ifb.ReqReady; o_ras = ifb.RAS;
        o_cas = ifb.CAS; o_we = ifb.WE; o_done = ifb.Done; o_busy = ifb.Busy;
      end
      default: begin
        o_addr = ifc.AddrOut; o_ready = ifc.ReqReady; o_ras = ifc.RAS;
        o_cas = ifc.CAS; o_we = ifc.WE; o_done = ifc.Done; o_busy = ifc.Busy;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] row,
                       input logic [7:0] col, input logic wr);
    case (which)
      0: begin ifa.ReqValid = v; ifa.ReqAddr = {row, col}; ifa.ReqWrite = wr; end
      1: begin ifb.ReqValid = v; ifb.ReqAddr = {row, col}; ifb.ReqWrite = wr; end
      default: begin ifc.ReqValid = v; ifc.ReqAddr = {row, col[5:0]}; ifc.ReqWrite = wr; end
    endcase
  endtask

  // Called at the negedge of accept cycle 0; returns at the negedge of the
  // cycle where ReqReady is expected back high.
  task automatic access(input int which, input logic [7:0] row, input logic [7:0] col,
                        input logic wr, input logic hold, input int trcd,
                        input int tcl, input int trp);
    int total = 2 + trcd + tcl + trp;
    int done_c = 1 + trcd + tcl;
    logic [7:0] exp_col = (which == 2) ? {2'b00, col[5:0]} : col;
    logic [7:0] ea;
    check("ready_at_accept", o_ready, 1);
    drive(which, 1'b1, row, col, wr);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) drive(which, 1'b0, ~row, ~col, ~wr);
      check($sformatf("c%0d ras", c), o_ras, (c == 1));
      check($sformatf("c%0d cas", c), o_cas, (c == 1 + trcd));
      check($sformatf("c%0d we", c), o_we, (c == 1 + trcd) && wr);
      check($sformatf("c%0d done", c), o_done, (c == done_c));
      check($sformatf("c%0d busy", c), o_busy, (c < total));
      check($sformatf("c%0d ready", c), o_ready, (c == total));
      check($sformatf("c%0d ras_cas_excl", c), o_ras & o_cas, 0);
      if (c <= trcd) ea = row;
      else if (c <= trcd + tcl) ea = exp_col;
      else ea = 8'h00;
      if (c != done_c) check($sformatf("c%0d addr", c), o_addr, ea);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel   = 0;
    reset = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    check("rst ready", o_ready, 0);
    check("rst addr", o_addr, 0);
    check("rst ras", o_ras, 0);
    check("rst cas", o_cas, 0);
    check("rst we", o_we, 0);
    check("rst done", o_done, 0);
    check("rst busy", o_busy, 0);
    reset = 1'b0;
    @(negedge clk);

    access(0, 8'h3C, 8'hA5, 1'b0, 1'b0, 2, 2, 2);
    @(negedge clk);
    access(0, 8'h01, 8'hFF, 1'b1, 1'b0, 2, 2, 2);
    @(negedge clk);
    access(0, 8'h55, 8'h66, 1'b1, 1'b1, 2, 2, 2);
    access(0, 8'h55, 8'h66, 1'b1, 1'b0, 2, 2, 2);
    @(negedge clk);

    // Abort by reset at cycle 2 of an access.
    check("abort ready0", o_ready, 1);
    drive(0, 1'b1, 8'h77, 8'h88, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("abort c1 ras", o_ras, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort c2 ready", o_ready, 0);
    @(negedge clk);
    check("abort c3 addr", o_addr, 0);
    check("abort c3 ras", o_ras, 0);
    check("abort c3 cas", o_cas, 0);
    check("abort c3 we", o_we, 0);
    check("abort c3 done", o_done, 0);
    check("abort c3 busy", o_busy, 0);
    reset = 1'b0;
    #1;
    check("abort c3 ready", o_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort post%0d cas", i), o_cas, 0);
      check($sformatf("abort post%0d done", i), o_done, 0);
    end
    access(0, 8'h9A, 8'hBC, 1'b0, 1'b0, 2, 2, 2);
    @(negedge clk);

    sel = 1;
    #1;
    access(1, 8'hC3, 8'h5A, 1'b1, 1'b0, 1, 1, 1);
    @(negedge clk);

    sel = 2;
    #1;
    access(2, 8'h12, 8'h3F, 1'b0, 1'b0, 2, 2, 2);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
